// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: arbitrates the register-file write port between core writeback,
// LSU load responses and mul/div responses; tracks pending destinations.
`default_nettype none

module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            core_valid,
  input  logic [4:0]      core_rd,
  input  logic [1:0]      result_src,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] pc_plus4,
  output logic            core_stall,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            md_issue,
  input  logic [4:0]      md_issue_rd,
  input  logic            md_valid,
  input  logic [4:0]      md_rd,
  input  logic [XLEN-1:0] md_data,
  output logic            md_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            hazard,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CORE = 2'd1,
    GNT_LSU  = 2'd2,
    GNT_MD   = 2'd3
  } gnt_e;

  gnt_e            gnt;
  logic            core_req;
  logic            load_issue;
  logic            starved;
  logic            rr_q, rr_d;          // 0: LSU preferred, 1: MD preferred
  logic [3:0]      starve_q, starve_d;
  logic [31:0]     pending_q, pending_d;
  logic [31:0]     set_v, clr_v;
  logic            we_d;
  logic [4:0]      waddr_d;
  logic [XLEN-1:0] wdata_d;

  assign core_req   = core_valid & (result_src != 2'b01);
  assign load_issue = core_valid & (result_src == 2'b01);
  assign starved    = (starve_q == LIMIT);

  always_comb begin
    gnt  = GNT_NONE;
    rr_d = rr_q;
    if (core_req && starved) begin
      gnt = GNT_CORE;
    end else if (lsu_valid && md_valid) begin
      gnt  = rr_q ? GNT_MD : GNT_LSU;
      rr_d = ~rr_q;
    end else if (lsu_valid) begin
      gnt = GNT_LSU;
    end else if (md_valid) begin
      gnt = GNT_MD;
    end else if (core_req) begin
      gnt = GNT_CORE;
    end
  end

  assign core_stall = core_req & (gnt != GNT_CORE);
  assign lsu_ready  = (gnt == GNT_LSU);
  assign md_ready   = (gnt == GNT_MD);

  always_comb begin
    starve_d = starve_q;
    if (gnt == GNT_CORE) begin
      starve_d = '0;
    end else if (core_stall && !starved) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    waddr_d = rf_waddr;
    wdata_d = rf_wdata;
    case (gnt)
      GNT_CORE: begin
        waddr_d = core_rd;
        wdata_d = result_src[1] ? pc_plus4 : alu_result;
      end
      GNT_LSU: begin
        waddr_d = lsu_rd;
        wdata_d = lsu_data;
      end
      GNT_MD: begin
        waddr_d = md_rd;
        wdata_d = md_data;
      end
      default: ;
    endcase
    we_d = (gnt != GNT_NONE) && (waddr_d != 5'd0);
  end

  // A new issue to a register overrides a same-cycle retirement to it.
  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (load_issue) set_v[core_rd] = 1'b1;
    if (md_issue)   set_v[md_issue_rd] = 1'b1;
    set_v[0] = 1'b0;
    if (lsu_ready) clr_v[lsu_rd] = 1'b1;
    if (md_ready)  clr_v[md_rd] = 1'b1;
    pending_d = (pending_q & ~clr_v) | set_v;
  end

  assign hazard = pending_q[rs1] | pending_q[rs2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= 1'b0;
      starve_q  <= '0;
      pending_q <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
    end else begin
      rr_q      <= rr_d;
      starve_q  <= starve_d;
      pending_q <= pending_d;
      rf_we     <= we_d;
      rf_waddr  <= waddr_d;
      rf_wdata  <= wdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: scoreboard bench with a behavioural model of the write-port arbiter.
`default_nettype none

module tb_wb_port_arbiter;

  localparam int XLEN   = 32;
  localparam int STARVE = 4;
  localparam int ID_NONE = 0, ID_CORE = 1, ID_LSU = 2, ID_MD = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            core_valid;
  logic [4:0]      core_rd;
  logic [1:0]      result_src;
  logic [XLEN-1:0] alu_result, pc_plus4;
  logic            core_stall;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            md_issue;
  logic [4:0]      md_issue_rd;
  logic            md_valid;
  logic [4:0]      md_rd;
  logic [XLEN-1:0] md_data;
  logic            md_ready;
  logic [4:0]      rs1, rs2;
  logic            hazard;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  wb_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_valid(core_valid), .core_rd(core_rd), .result_src(result_src),
    .alu_result(alu_result), .pc_plus4(pc_plus4), .core_stall(core_stall),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .md_issue(md_issue), .md_issue_rd(md_issue_rd),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            we;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  bit  mon_en  = 0;

  // Model state
  bit  m_pend[32];
  int  m_starve;
  int  m_rr;          // 0: LSU next on a tie, 1: MD next
  bit  last_stall, last_lsu_acc, last_md_acc;
  int  grant_log[$];

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_starve = 0;
    m_rr = 0;
    last_stall = 0; last_lsu_acc = 0; last_md_acc = 0;
  endtask

  // Evaluate one cycle of the reference behaviour against the inputs on the pins.
  task automatic step();
    bit creq;
    int who;
    wr_t w;
    creq = core_valid && (result_src != 2'b01);
    who = ID_NONE;
    if (creq && m_starve == STARVE) who = ID_CORE;
    else if (lsu_valid && md_valid) begin
      who = (m_rr == 0) ? ID_LSU : ID_MD;
      m_rr = 1 - m_rr;
    end
    else if (lsu_valid) who = ID_LSU;
    else if (md_valid) who = ID_MD;
    else if (creq) who = ID_CORE;
    grant_log.push_back(who);

    chk("core_stall", 32'(core_stall), 32'(creq && who != ID_CORE));
    chk("lsu_ready", 32'(lsu_ready), 32'(who == ID_LSU));
    chk("md_ready", 32'(md_ready), 32'(who == ID_MD));
    chk("hazard", 32'(hazard), 32'(m_pend[rs1] || m_pend[rs2]));

    w.addr = 0; w.data = 0;
    if (who == ID_CORE) begin
      w.addr = core_rd; w.data = result_src[1] ? pc_plus4 : alu_result;
    end else if (who == ID_LSU) begin
      w.addr = lsu_rd; w.data = lsu_data;
    end else if (who == ID_MD) begin
      w.addr = md_rd; w.data = md_data;
    end
    w.we = (who != ID_NONE) && (w.addr != 0);
    exp_q.push_back(w);

    if (who == ID_CORE) m_starve = 0;
    else if (creq && m_starve < STARVE) m_starve++;

    if (who == ID_LSU) m_pend[lsu_rd] = 0;
    if (who == ID_MD) m_pend[md_rd] = 0;
    if (core_valid && result_src == 2'b01 && core_rd != 0) m_pend[core_rd] = 1;
    if (md_issue && md_issue_rd != 0) m_pend[md_issue_rd] = 1;

    last_stall   = creq && who != ID_CORE;
    last_lsu_acc = (who == ID_LSU);
    last_md_acc  = (who == ID_MD);
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic cyc();
    #1;
    step();
    @(negedge clk);
  endtask

  task automatic idle();
    core_valid = 0; core_rd = 0; result_src = 0; alu_result = 0; pc_plus4 = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    md_issue = 0; md_issue_rd = 0; md_valid = 0; md_rd = 0; md_data = 0;
    rs1 = 0; rs2 = 0;
  endtask

  task automatic rand_inputs();
    if (!last_stall) begin
      core_valid = 1'($urandom_range(0, 1));
      core_rd    = 5'($urandom_range(0, 7));
      result_src = 2'($urandom_range(0, 3));
      alu_result = $urandom;
      pc_plus4   = $urandom;
    end
    if (!(lsu_valid && !last_lsu_acc)) begin
      lsu_valid = 1'($urandom_range(0, 1));
      lsu_rd    = 5'($urandom_range(0, 7));
      lsu_data  = $urandom;
    end
    if (!(md_valid && !last_md_acc)) begin
      md_valid = 1'($urandom_range(0, 1));
      md_rd    = 5'($urandom_range(0, 7));
      md_data  = $urandom;
    end
    md_issue    = 1'($urandom_range(0, 3) == 0);
    md_issue_rd = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
  endtask

  // Monitor: every registered write is compared to the scoreboard entry of the prior cycle.
  initial begin
    wr_t e;
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL scoreboard_empty: got rf_we=%0b expected an entry", rf_we);
        end else begin
          e = exp_q.pop_front();
          chk("rf_we", 32'(rf_we), 32'(e.we));
          if (e.we && rf_we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
            chk("rf_wdata", rf_wdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    int base;
    idle();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_core_stall", 32'(core_stall), 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);
    @(negedge clk);
    rst_n = 1;
    mon_en = 1;

    // ALU write
    core_valid = 1; core_rd = 5; result_src = 2'b00; alu_result = 32'h1234; cyc();
    // JAL with both PC+4 encodings
    core_rd = 1; result_src = 2'b10; pc_plus4 = 32'h104; cyc();
    result_src = 2'b11; pc_plus4 = 32'h108; cyc();
    // Load issue then response
    core_rd = 7; result_src = 2'b01; cyc();
    core_valid = 0; rs1 = 7; cyc();
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hAA; cyc();
    lsu_valid = 0; cyc();
    chk("load_hazard_cleared", 32'(hazard), 32'd0);

    // Three-way conflict held for six cycles
    base = grant_log.size();
    core_valid = 1; core_rd = 4; result_src = 2'b00; alu_result = 32'hC0DE;
    lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h11;
    md_valid = 1; md_rd = 3; md_data = 32'h22;
    repeat (6) cyc();
    chk("conflict_g0", 32'(grant_log[base+0]), 32'(ID_LSU));
    chk("conflict_g1", 32'(grant_log[base+1]), 32'(ID_MD));
    chk("conflict_g2", 32'(grant_log[base+2]), 32'(ID_LSU));
    chk("conflict_g3", 32'(grant_log[base+3]), 32'(ID_MD));
    chk("conflict_g4", 32'(grant_log[base+4]), 32'(ID_CORE));
    idle(); cyc();

    // x0 response and set-wins on the same register
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'hDEAD; cyc();
    lsu_valid = 0; md_issue = 1; md_issue_rd = 3; md_valid = 1; md_rd = 3; md_data = 32'h33; cyc();
    idle(); rs1 = 3; cyc();
    chk("set_wins_hazard", 32'(hazard), 32'd1);

    // Randomised traffic
    idle();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      cyc();
    end

    // Asynchronous reset with loads pending and a write on the port
    idle(); cyc();
    core_valid = 1; result_src = 2'b01; core_rd = 9; cyc();
    core_rd = 10; cyc();
    core_rd = 11; lsu_valid = 1; lsu_rd = 12; lsu_data = 32'h5A5A; rs1 = 9; cyc();
    mon_en = 0;
    chk("pre_rst_rf_we", 32'(rf_we), 32'd1);
    chk("pre_rst_hazard", 32'(hazard), 32'd1);
    rst_n = 0;
    #1;
    chk("async_rst_rf_we", 32'(rf_we), 32'd0);
    chk("async_rst_hazard", 32'(hazard), 32'd0);
    chk("async_rst_waddr", 32'(rf_waddr), 32'd0);
    idle();
    #20;
    rst_n = 1;
    #10;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
